// File: rtl/bitlet_acc_drain_pkg.sv
// Shared widths and FSM encoding for the Bitlet PE output stage.
package bitlet_acc_drain_pkg;
  localparam int WID_SUM   = 16;
  localparam int W_LEN_DEF = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;
endpackage

// File: rtl/bitlet_acc_drain_if.sv
// Partial-sum input stream and accumulated-result output stream of the drain stage.
interface bitlet_acc_drain_if
  import bitlet_acc_drain_pkg::*;
#(
  parameter int W_IN  = WID_SUM,
  parameter int W_ACC = WID_SUM + W_LEN_DEF
);
  // SUM: SUM_vld qualifies SUM, no backpressure. ACC: a beat transfers on the
  // edge where ACC_vld && ACC_rdy; ACC is held stable while ACC_vld && !ACC_rdy.
  logic             SUM_vld;
  logic [W_IN-1:0]  SUM;
  logic             ACC_vld;
  logic             ACC_rdy;
  logic [W_ACC-1:0] ACC;

  modport master (output SUM_vld, SUM, ACC_rdy, input ACC_vld, ACC);
  modport slave  (input SUM_vld, SUM, ACC_rdy, output ACC_vld, ACC);
endinterface

// File: rtl/bitlet_acc_fifo2.sv
// Two-entry result FIFO with registered head; a pop frees a slot for a same-cycle push.
module bitlet_acc_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         valid,
  output logic [W-1:0] head
);
  logic [1:0]   count_q;
  logic [W-1:0] head_q;
  logic [W-1:0] tail_q;
  logic         pop_ok;
  logic         push_ok;

  assign valid   = (count_q != 2'd0);
  assign full    = (count_q == 2'd2);
  assign head    = head_q;
  assign pop_ok  = pop && valid;
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else if (flush) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      unique case ({push_ok, pop_ok})
        2'b11: begin
          if (count_q == 2'd2) begin
            head_q <= tail_q;
            tail_q <= din;
          end else begin
            head_q <= din;
          end
        end
        2'b01: begin
          if (count_q == 2'd2) head_q <= tail_q;
          count_q <= count_q - 2'd1;
        end
        2'b10: begin
          if (count_q == 2'd0) head_q <= din;
          else                 tail_q <= din;
          count_q <= count_q + 2'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/bitlet_acc_drain.sv
// Bitlet PE output stage: sums N partial sums per group and drains results through a 2-entry FIFO.
module bitlet_acc_drain
  import bitlet_acc_drain_pkg::*;
#(
  parameter int W_IN  = WID_SUM,
  parameter int W_LEN = W_LEN_DEF,
  parameter int W_ACC = W_IN + W_LEN
) (
  input  logic             clk,
  input  logic             rst_n,
  bitlet_acc_drain_if.slave bus,
  input  logic [W_LEN-1:0] cfg_len,
  input  logic             clr,
  output logic             grp_busy,
  output logic             ovf_err,
  output state_t           state_dbg
);
  state_t                   state_q, state_d;
  logic [W_LEN-1:0]         len_q, len_d;
  logic [W_LEN-1:0]         cnt_q, cnt_d;
  logic signed [W_ACC-1:0]  acc_q, acc_d;
  logic signed [W_ACC-1:0]  sum_ext;
  logic signed [W_ACC-1:0]  acc_sum;
  logic signed [W_ACC-1:0]  push_data;
  logic                     push;
  logic                     beat;
  logic                     fifo_full;
  logic                     drop;

  assign sum_ext = W_ACC'($signed(bus.SUM));
  assign acc_sum = acc_q + sum_ext;
  assign beat    = bus.SUM_vld && !clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    push      = 1'b0;
    push_data = '0;
    if (clr) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      acc_d   = '0;
    end else if (beat) begin
      unique case (state_q)
        ST_IDLE: begin
          // cfg_len is only sampled here, so it may change freely mid-group.
          len_d = cfg_len;
          cnt_d = W_LEN'(1);
          acc_d = sum_ext;
          if (cfg_len == '0) begin
            push      = 1'b1;
            push_data = sum_ext;
          end else begin
            state_d = ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          acc_d = acc_sum;
          if (cnt_q == len_q) begin
            push      = 1'b1;
            push_data = acc_sum;
            cnt_d     = '0;
            state_d   = ST_IDLE;
          end else begin
            cnt_d = cnt_q + W_LEN'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // A same-cycle pop makes room, so only a stalled full FIFO drops a result.
  assign drop = push && fifo_full && !(bus.ACC_vld && bus.ACC_rdy);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    ovf_err <= 1'b0;
    else if (clr)  ovf_err <= 1'b0;
    else if (drop) ovf_err <= 1'b1;
  end

  bitlet_acc_fifo2 #(.W(W_ACC)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (clr),
    .push  (push),
    .din   (push_data),
    .pop   (bus.ACC_rdy),
    .full  (fifo_full),
    .valid (bus.ACC_vld),
    .head  (bus.ACC)
  );

  assign grp_busy  = (state_q == ST_ACCUM);
  assign state_dbg = state_q;
endmodule

// File: tb/tb_bitlet_acc_drain.sv
// Directed bench for bitlet_acc_drain: hand-computed results checked at the output handshake.
module tb_bitlet_acc_drain;
  import bitlet_acc_drain_pkg::*;

  localparam int W_IN  = WID_SUM;
  localparam int W_LEN = W_LEN_DEF;
  localparam int W_ACC = W_IN + W_LEN;

  logic             clk;
  logic             rst_n;
  logic [W_LEN-1:0] cfg_len;
  logic             clr;
  logic             grp_busy;
  logic             ovf_err;
  state_t           state_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W_ACC-1:0] exp_q[$];

  bitlet_acc_drain_if #(.W_IN(W_IN), .W_ACC(W_ACC)) bus ();

  bitlet_acc_drain #(.W_IN(W_IN), .W_LEN(W_LEN), .W_ACC(W_ACC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .cfg_len   (cfg_len),
    .clr       (clr),
    .grp_busy  (grp_busy),
    .ovf_err   (ovf_err),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] sx(input logic [W_ACC-1:0] v);
    return 32'($signed(v));
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int s, input int len);
    bus.SUM_vld = 1'b1;
    bus.SUM     = W_IN'(s);
    cfg_len     = W_LEN'(len);
    tick();
    bus.SUM_vld = 1'b0;
  endtask

  task automatic expect_result(input int v);
    exp_q.push_back(W_ACC'(v));
  endtask

  // scoreboard: every handshake must match the next expected result
  always @(negedge clk) begin
    if (rst_n && bus.ACC_vld && bus.ACC_rdy) begin
      check_eq("pop_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check_eq("pop_data", sx(bus.ACC), sx(exp_q.pop_front()));
    end
  end

  initial begin
    rst_n       = 1'b0;
    clr         = 1'b0;
    cfg_len     = '0;
    bus.SUM_vld = 1'b0;
    bus.SUM     = '0;
    bus.ACC_rdy = 1'b0;
    repeat (3) tick();

    check_eq("rst_acc_vld", 32'(bus.ACC_vld), 0);
    check_eq("rst_acc", sx(bus.ACC), 0);
    check_eq("rst_busy", 32'(grp_busy), 0);
    check_eq("rst_ovf", 32'(ovf_err), 0);
    check_eq("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    rst_n = 1'b1;
    tick();

    // single group of four beats
    bus.ACC_rdy = 1'b1;
    expect_result(110);
    beat(5, 3);
    check_eq("grp_busy_after_first", 32'(grp_busy), 1);
    check_eq("grp_no_early_result", 32'(bus.ACC_vld), 0);
    beat(-2, 0);
    beat(7, 0);
    check_eq("grp_busy_before_last", 32'(grp_busy), 1);
    beat(100, 0);
    check_eq("grp_vld_latency", 32'(bus.ACC_vld), 1);
    check_eq("grp_acc", sx(bus.ACC), 110);
    check_eq("grp_busy_done", 32'(grp_busy), 0);
    tick();
    check_eq("grp_single_result", 32'(bus.ACC_vld), 0);

    // back-to-back length-0 groups
    expect_result(-1);
    expect_result(2);
    expect_result(-3);
    beat(-1, 0);
    check_eq("len0_a", sx(bus.ACC), 32'(-1));
    beat(2, 0);
    check_eq("len0_b", sx(bus.ACC), 2);
    beat(-3, 0);
    check_eq("len0_c", sx(bus.ACC), 32'(-3));
    check_eq("len0_c_vld", 32'(bus.ACC_vld), 1);
    tick();
    check_eq("len0_drained", 32'(bus.ACC_vld), 0);

    // 256 beats of the most-negative input
    expect_result(-8388608);
    beat(-32768, 255);
    for (int i = 1; i < 256; i++) beat(-32768, i % 7);
    check_eq("extreme_acc", sx(bus.ACC), 32'(-8388608));
    check_eq("extreme_vld", 32'(bus.ACC_vld), 1);
    tick();

    // backpressure: third result dropped
    bus.ACC_rdy = 1'b0;
    expect_result(11);
    expect_result(22);
    beat(11, 0);
    beat(22, 0);
    check_eq("bp_no_ovf_yet", 32'(ovf_err), 0);
    beat(33, 0);
    check_eq("bp_ovf", 32'(ovf_err), 1);
    tick();
    tick();
    check_eq("bp_hold_vld", 32'(bus.ACC_vld), 1);
    check_eq("bp_hold_acc", sx(bus.ACC), 11);
    bus.ACC_rdy = 1'b1;
    tick();
    check_eq("bp_second", sx(bus.ACC), 22);
    tick();
    check_eq("bp_empty", 32'(bus.ACC_vld), 0);
    check_eq("bp_ovf_sticky", 32'(ovf_err), 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_eq("bp_ovf_cleared", 32'(ovf_err), 0);

    // full FIFO, completing beat coincides with a pop
    bus.ACC_rdy = 1'b0;
    expect_result(1);
    expect_result(2);
    expect_result(3);
    beat(1, 0);
    beat(2, 0);
    bus.ACC_rdy = 1'b1;
    beat(3, 0);
    check_eq("pp_no_ovf", 32'(ovf_err), 0);
    check_eq("pp_head", sx(bus.ACC), 2);
    tick();
    check_eq("pp_tail", sx(bus.ACC), 3);
    tick();
    check_eq("pp_empty", 32'(bus.ACC_vld), 0);

    // clr mid-group with pending outputs and an overflow
    bus.ACC_rdy = 1'b0;
    beat(77, 0);
    beat(78, 0);
    beat(79, 0);
    check_eq("clr_pre_ovf", 32'(ovf_err), 1);
    beat(10, 3);
    check_eq("clr_pre_busy", 32'(grp_busy), 1);
    clr = 1'b1;
    beat(20, 0);
    clr = 1'b0;
    check_eq("clr_vld", 32'(bus.ACC_vld), 0);
    check_eq("clr_busy", 32'(grp_busy), 0);
    check_eq("clr_ovf", 32'(ovf_err), 0);
    check_eq("clr_state", 32'(state_dbg), 32'(ST_IDLE));
    bus.ACC_rdy = 1'b1;
    expect_result(9);
    beat(4, 1);
    beat(5, 0);
    check_eq("clr_fresh_acc", sx(bus.ACC), 9);
    tick();

    // asynchronous reset mid-group with a pending output
    bus.ACC_rdy = 1'b0;
    beat(55, 0);
    beat(1, 3);
    beat(2, 0);
    rst_n = 1'b0;
    #1;
    check_eq("arst_vld", 32'(bus.ACC_vld), 0);
    check_eq("arst_acc", sx(bus.ACC), 0);
    check_eq("arst_busy", 32'(grp_busy), 0);
    check_eq("arst_ovf", 32'(ovf_err), 0);
    check_eq("arst_state", 32'(state_dbg), 32'(ST_IDLE));
    tick();
    rst_n = 1'b1;
    bus.ACC_rdy = 1'b1;
    expect_result(8);
    beat(8, 0);
    check_eq("arst_after", sx(bus.ACC), 8);
    tick();
    tick();

    check_eq("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/bitlet_acc_drain.md
# bitlet_acc_drain

Output stage of the Bitlet PE. Sits directly downstream of the 24-input compressor/adder tree and consumes its `SUM_vld`/`SUM` stream. It adds a programmable number of consecutive partial sums, one per weight-bit group, into one exact signed result. Completed results are buffered in a 2-entry FIFO and drained over a valid/ready handshake to the PE output or writeback path.

## Interface

**Parameters**
- `W_IN`, default `` `Wid_sum ``: width of the incoming signed partial sum.
- `W_LEN`, default 8: width of the group-length configuration.
- `W_ACC`, default `W_IN+W_LEN`: accumulator and result width. It is wide enough that no overflow is possible.

**Ports**
- `clk`, in, 1: the single clock.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `SUM_vld`, in, 1: partial sum valid. There is no backpressure on this port.
- `SUM`, in, `W_IN`: signed partial sum from the tree.
- `cfg_len`, in, `W_LEN`: partial sums per group, encoded as N-1 (0 means 1, 255 means 256). Sampled on the first beat of each group.
- `clr`, in, 1: synchronous abort. Discards the group in progress and flushes the FIFO.
- `ACC_vld`, out, 1: FIFO head valid.
- `ACC_rdy`, in, 1: consumer ready.
- `ACC`, out, `W_ACC`: signed accumulated result (FIFO head).
- `grp_busy`, out, 1: high while in ACCUM state.
- `ovf_err`, out, 1: sticky flag, set when a result is dropped because the FIFO is full. Cleared only by `clr` or reset.

## Operation

**State machine**
- IDLE to ACCUM: on `SUM_vld` when the latched length is greater than 0.
- ACCUM to IDLE: on the beat where the beat counter equals the latched length.
- Length 0 (one beat): stay in IDLE and push the result immediately.

**Data path, first beat (IDLE)**
- `len_q <= cfg_len`.
- `cnt <= 1`.
- `acc <= sext(SUM)`.

**Data path, later beats (ACCUM)**
- `acc <= acc + sext(SUM)`.
- `cnt <= cnt + 1`.
- `cfg_len` is ignored during a group.

**Completion**
- The group completes on the last beat.
- The result pushed is `acc + sext(SUM)`, or `sext(SUM)` for a length-0 group.
- All arithmetic is two's complement at `W_ACC` width, with no saturation and no rounding.

**Output FIFO**
- Depth 2, with registered head.
- Pop happens on `ACC_vld && ACC_rdy`.
- Push and pop in the same cycle are both performed, including when the FIFO is full: the pop frees the slot first.
- If a push arrives while the FIFO is full and there is no pop, the result is dropped, the FIFO is unchanged, and `ovf_err` is set.

**`clr`**
- Takes priority over everything else.
- Returns to IDLE, sets `cnt` to 0 and `acc` to 0.
- Empties the FIFO, so `ACC_vld` is 0 next cycle.
- Clears `ovf_err`.
- A `SUM_vld` in the same cycle as `clr` is discarded.

**Gaps in `SUM_vld`**
- Gaps inside a group are allowed. State holds and there is no timeout.

## Timing

**Reset values**
- `ACC_vld` 0, `ACC` 0, `grp_busy` 0, `ovf_err` 0.
- State IDLE, `cnt` 0, `acc` 0, FIFO empty.
- Reset asserted mid-group or with a full FIFO discards everything immediately.

**Latency**
- Last `SUM` beat sampled at edge t: `ACC_vld` is high and `ACC` is valid after edge t, when the FIFO was empty before t.

**Handshake rules**
- `ACC` holds stable while `ACC_vld && !ACC_rdy`.
- `ACC_vld` never drops without a pop, except on `clr` or reset.

**Throughput**
- One group per N beats with no bubbles: a new group's first beat may arrive on the cycle after the previous group's last beat.
- Back-to-back length-0 groups push one result per cycle.

**Flag timing**
- `grp_busy` is registered and is high from the cycle after the first beat through the cycle of the last beat.

## Structure

- **Shared package / defines header:** `` `Wid_sum ``, the `W_LEN` default, and the IDLE/ACCUM state encoding.
- **Sub-module `bitlet_acc_fifo2`:** parameterised by width. A 2-entry synchronous FIFO with a flush input, push/pop ports, a full output and valid/head outputs.
- **Top level:** holds the FSM, the counter, the accumulator and the overflow logic.

## Test plan

- **Single group.** `cfg_len`=3, `SUM`=5, -2, 7, 100 on consecutive cycles, with `ACC_rdy`=1 -> exactly one result, `ACC`=110, `ACC_vld` one cycle after the 4th beat.
- **Length-0 back-to-back.** `cfg_len`=0, `SUM`=-1, 2, -3 on consecutive cycles -> three results -1, 2, -3 on consecutive cycles.
- **Extreme magnitudes.** `cfg_len`=255, 256 beats of the most-negative `W_IN` value -> `ACC` = -2^(`W_IN`-1)·256 exactly, with no wrap.
- **Backpressure.** `ACC_rdy`=0, three length-0 groups -> the first two results are held in order, the third is dropped, and `ovf_err`=1. Then `ACC_rdy`=1 -> first and second results drain, `ovf_err` stays 1.
- **Full FIFO with simultaneous push and pop.** FIFO full, a completing beat coincides with a pop -> no drop, `ovf_err` stays 0, output order preserved.
- **`clr` and reset mid-group.** `clr` pulsed on beat 2 of a length-4 group with a pending output -> `ACC_vld`=0 and `grp_busy`=0 next cycle, and `ovf_err` cleared. A fresh group then accumulates from zero. Repeat with `rst_n` low mid-group -> all outputs return to their reset values.
